ahb_pixel_master: RTL

AHB_PIXEL_MASTER -- requirements
Module: ahb_pixel_master

---
 rtl/ahb_pixel_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ahb_pixel_master.sv
// Single-transfer AHB master that moves a 4x4 grid of 4-bit pixels plus brightness (68-bit beat).
// IDLE -> ADDR -> DATA -> RESP; all outputs registered from the next state; stalls bounded by TIMEOUT.
module ahb_pixel_master #(
  parameter int TIMEOUT = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [3:0][3:0][3:0]   req_pixels,
  input  logic [3:0]             req_brightness,
  output logic                   req_ready,
  output logic [31:0]            HADDR,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [2:0]             HSIZE,
  output logic [67:0]            HWDATA,
  input  logic                   HREADY,
  input  logic [67:0]            HRDATA,
  output logic                   rsp_valid,
  output logic [67:0]            rsp_rdata,
  output logic                   rsp_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [7:0]           wcnt_q, wcnt_d;
  logic                 req_ready_q, req_ready_d;
  logic [31:0]          haddr_q, haddr_d;
  logic                 hwrite_q, hwrite_d;
  logic [1:0]           htrans_q, htrans_d;
  logic [67:0]          hwdata_q, hwdata_d;
  logic [3:0][3:0][3:0] pix_q, pix_d;
  logic [3:0]           bri_q, bri_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [67:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 timeout_hit;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    pix_d       = pix_q;
    bri_d       = bri_q;
    rsp_rdata_d = rsp_rdata_q;
    timeout_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = S_ADDR;
          wcnt_d   = 8'd0;
          haddr_d  = req_addr;
          hwrite_d = req_write;
          pix_d    = req_pixels;
          bri_d    = req_brightness;
        end
      end
      S_ADDR, S_DATA: begin
        if (HREADY) begin
          wcnt_d  = 8'd0;
          state_d = (state_q == S_ADDR) ? S_DATA : S_RESP;
          if (state_q == S_DATA && !hwrite_q) begin
            rsp_rdata_d = HRDATA;
          end
        end else begin
          wcnt_d = wcnt_q + 8'd1;
          // The stall that brings the counter up to TIMEOUT ends the transfer.
          if (wcnt_q == WAIT_LAST) begin
            timeout_hit = 1'b1;
            state_d     = S_RESP;
            rsp_rdata_d = 68'd0;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d   = (state_d == S_IDLE);
    htrans_d      = (state_d == S_ADDR) ? 2'b10 : 2'b00;
    hwdata_d      = (state_d == S_DATA && hwrite_d) ? {pix_d, bri_d} : 68'd0;
    rsp_valid_d   = (state_d == S_RESP);
    rsp_timeout_d = timeout_hit;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      wcnt_q        <= 8'd0;
      req_ready_q   <= 1'b0;
      haddr_q       <= 32'd0;
      hwrite_q      <= 1'b0;
      htrans_q      <= 2'b00;
      hwdata_q      <= 68'd0;
      pix_q         <= '0;
      bri_q         <= 4'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 68'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      req_ready_q   <= req_ready_d;
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      htrans_q      <= htrans_d;
      hwdata_q      <= hwdata_d;
      pix_q         <= pix_d;
      bri_q         <= bri_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = 3'b010;
  assign HWDATA      = hwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
